// File: rtl/pwm_ramp_sequencer_pkg.sv
// Shared definitions for the PWM ramp sequencer: config register map,
// sequencer state encoding and the width clamp helper.
package pwm_ramp_sequencer_pkg;

  localparam logic [7:0] TGT_BASE  = 8'h00;
  localparam logic [7:0] RATE_BASE = 8'h20;
  localparam logic [7:0] EN_ADDR   = 8'h30;
  localparam logic [7:0] STAT_ADDR = 8'h31;
  localparam logic [7:0] CUR_BASE  = 8'h40;

  localparam int DEFAULT_MAX_WIDTH = 20000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_WR_LO = 3'd2,
    ST_WR_HI = 3'd3,
    ST_NEXT  = 3'd4
  } state_e;

  function automatic logic [15:0] clamp_width(input logic [15:0] w, input int max_w);
    return ({16'b0, w} > 32'(max_w)) ? 16'(max_w) : w;
  endfunction

endpackage

// File: rtl/pwm_step_calc.sv
// Combinational slew unit: moves cur one rate-sized step toward tgt without
// overshooting; a zero rate jumps straight to the target.
module pwm_step_calc (
  input  logic [15:0] cur,
  input  logic [15:0] tgt,
  input  logic [7:0]  rate,
  output logic [15:0] new_width
);

  logic [16:0] up_sum;
  logic [16:0] down_diff;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else leaves it unassigned and infers a latch.
  always_comb begin
    up_sum    = {1'b0, cur} + {9'b0, rate};
    down_diff = {1'b0, cur} - {9'b0, rate};
    new_width = cur;
    if (rate == 8'd0) begin
      new_width = tgt;
    end else if (cur < tgt) begin
      new_width = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[15:0];
    end else if (cur > tgt) begin
      // bit 16 set means cur - rate went below zero
      new_width = (down_diff[16] || (down_diff[15:0] <= tgt)) ? tgt : down_diff[15:0];
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Frame-paced slew controller: on each frame tick, steps every enabled channel
// toward its target and pushes changed widths to the PWM register file.
module pwm_ramp_sequencer
  import pwm_ramp_sequencer_pkg::*;
#(
  parameter int         NUM_CH    = 8,
  parameter int         MAX_WIDTH = DEFAULT_MAX_WIDTH,
  parameter logic [7:0] PWM_BASE  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_wen,
  input  logic [7:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] cfg_rdata,
  input  logic       frame_tick,
  output logic       pwm_wen,
  output logic [7:0] pwm_addr,
  output logic [7:0] pwm_wdata,
  output logic       busy,
  output logic       overrun
);

  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  logic [15:0] tgt_q  [NUM_CH];
  logic [15:0] tgt_d  [NUM_CH];
  logic [7:0]  rate_q [NUM_CH];
  logic [7:0]  rate_d [NUM_CH];
  logic [15:0] cur_q  [NUM_CH];
  logic [15:0] cur_d  [NUM_CH];
  logic [7:0]  en_q, en_d;
  state_e      state_q, state_d;
  logic [2:0]  ch_q, ch_d;
  logic        busy_q, busy_d;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic        pwm_wen_q, pwm_wen_d;
  logic [7:0]  pwm_addr_q, pwm_addr_d;
  logic [7:0]  pwm_wdata_q, pwm_wdata_d;
  logic [15:0] step_width;

  pwm_step_calc u_step (
    .cur       (cur_q[ch_q]),
    .tgt       (tgt_q[ch_q]),
    .rate      (rate_q[ch_q]),
    .new_width (step_width)
  );

  always_comb begin
    tgt_d       = tgt_q;
    rate_d      = rate_q;
    cur_d       = cur_q;
    en_d        = en_q;
    state_d     = state_q;
    ch_d        = ch_q;
    busy_d      = busy_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    pwm_wen_d   = 1'b0;
    pwm_addr_d  = pwm_addr_q;
    pwm_wdata_d = pwm_wdata_q;

    if (cfg_wen) begin
      if (cfg_addr[7:4] == TGT_BASE[7:4] && int'(cfg_addr[3:1]) < NUM_CH) begin
        // the clamp is judged on the complete value once the high byte lands
        if (cfg_addr[0])
          tgt_d[cfg_addr[3:1]] = clamp_width({cfg_wdata, tgt_q[cfg_addr[3:1]][7:0]}, MAX_WIDTH);
        else
          tgt_d[cfg_addr[3:1]][7:0] = cfg_wdata;
      end else if (cfg_addr[7:3] == RATE_BASE[7:3] && int'(cfg_addr[2:0]) < NUM_CH) begin
        rate_d[cfg_addr[2:0]] = cfg_wdata;
      end else if (cfg_addr == EN_ADDR) begin
        en_d = cfg_wdata;
      end else if (cfg_addr == STAT_ADDR) begin
        overrun_d = 1'b0;
      end
    end

    // A lost tick wins over a same-cycle status clear.
    if (frame_tick && state_q != ST_IDLE) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_tick && en_q != 8'd0) begin
          state_d = ST_CALC;
          ch_d    = 3'd0;
          busy_d  = 1'b1;
        end
      end
      ST_CALC: begin
        if (!en_q[ch_q] || step_width == cur_q[ch_q]) begin
          state_d = ST_NEXT;
        end else begin
          cur_d[ch_q] = step_width;
          state_d     = ST_WR_LO;
          pwm_wen_d   = 1'b1;
          pwm_addr_d  = PWM_BASE + {4'b0, ch_q, 1'b0};
          pwm_wdata_d = step_width[7:0];
        end
      end
      ST_WR_LO: begin
        state_d     = ST_WR_HI;
        pwm_wen_d   = 1'b1;
        pwm_addr_d  = PWM_BASE + {4'b0, ch_q, 1'b1};
        pwm_wdata_d = cur_q[ch_q][15:8];
      end
      ST_WR_HI: state_d = ST_NEXT;
      ST_NEXT: begin
        if (ch_q == LAST_CH) begin
          if (pending_q || frame_tick) begin
            state_d   = ST_CALC;
            ch_d      = 3'd0;
            pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          state_d = ST_CALC;
          ch_d    = ch_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the per-channel arrays are reset along with the control flops so
  // every readback is defined as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_q[i]  <= '0;
        rate_q[i] <= '0;
        cur_q[i]  <= '0;
      end
      en_q        <= '0;
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      busy_q      <= 1'b0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      pwm_wen_q   <= 1'b0;
      pwm_addr_q  <= '0;
      pwm_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      tgt_q       <= tgt_d;
      rate_q      <= rate_d;
      cur_q       <= cur_d;
      en_q        <= en_d;
      state_q     <= state_d;
      ch_q        <= ch_d;
      busy_q      <= busy_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      pwm_wen_q   <= pwm_wen_d;
      pwm_addr_q  <= pwm_addr_d;
      pwm_wdata_q <= pwm_wdata_d;
    end
  end

  always_comb begin
    cfg_rdata = 8'h00;
    if (cfg_addr[7:4] == TGT_BASE[7:4]) begin
      if (int'(cfg_addr[3:1]) < NUM_CH)
        cfg_rdata = cfg_addr[0] ? tgt_q[cfg_addr[3:1]][15:8] : tgt_q[cfg_addr[3:1]][7:0];
    end else if (cfg_addr[7:3] == RATE_BASE[7:3]) begin
      if (int'(cfg_addr[2:0]) < NUM_CH) cfg_rdata = rate_q[cfg_addr[2:0]];
    end else if (cfg_addr == EN_ADDR) begin
      cfg_rdata = en_q;
    end else if (cfg_addr == STAT_ADDR) begin
      cfg_rdata = {6'b0, overrun_q, busy_q};
    end else if (cfg_addr[7:4] == CUR_BASE[7:4]) begin
      if (int'(cfg_addr[3:1]) < NUM_CH)
        cfg_rdata = cfg_addr[0] ? cur_q[cfg_addr[3:1]][15:8] : cur_q[cfg_addr[3:1]][7:0];
    end
  end

  assign pwm_wen   = pwm_wen_q;
  assign pwm_addr  = pwm_addr_q;
  assign pwm_wdata = pwm_wdata_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer: register-map vector table,
// directed ramp/overlap/reset sequences and randomized frames against a model.
module tb_pwm_ramp_sequencer;

  localparam int NUM_CH = 8;
  localparam int MAX_W  = 20000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_wen = 1'b0;
  logic [7:0] cfg_addr = 8'h00;
  logic [7:0] cfg_wdata = 8'h00;
  logic [7:0] cfg_rdata;
  logic       frame_tick = 1'b0;
  logic       pwm_wen;
  logic [7:0] pwm_addr;
  logic [7:0] pwm_wdata;
  logic       busy;
  logic       overrun;

  pwm_ramp_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_wen    (cfg_wen),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .frame_tick (frame_tick),
    .pwm_wen    (pwm_wen),
    .pwm_addr   (pwm_addr),
    .pwm_wdata  (pwm_wdata),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tick_cyc = 0;
  int last_base = 0;

  logic [15:0] got_wr[$];
  int          wr_cyc[$];
  logic [15:0] exp_wr[$];
  int          exp_busy;

  // behavioural model state
  int tgt_m  [NUM_CH];
  int rate_m [NUM_CH];
  int cur_m  [NUM_CH];
  int en_m;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pwm_wen) begin
      got_wr.push_back({pwm_addr, pwm_wdata});
      wr_cyc.push_back(cyc);
    end
  end

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      tgt_m[n] = 0; rate_m[n] = 0; cur_m[n] = 0;
    end
    en_m = 0;
  endtask

  task automatic model_cfg(input logic [7:0] a, input logic [7:0] d);
    int n, v;
    if (a < 8'h10) begin
      n = int'(a) / 2;
      if (a[0]) begin
        v = int'(d) * 256 + (tgt_m[n] % 256);
        tgt_m[n] = (v > MAX_W) ? MAX_W : v;
      end else begin
        tgt_m[n] = (tgt_m[n] / 256) * 256 + int'(d);
      end
    end else if (a >= 8'h20 && a <= 8'h27) begin
      rate_m[int'(a) - 32] = int'(d);
    end else if (a == 8'h30) begin
      en_m = int'(d);
    end
  endtask

  // One frame: each enabled channel moves min(rate, distance) toward target.
  task automatic model_frame();
    int c, t, r, nw;
    if (en_m == 0) return;
    for (int n = 0; n < NUM_CH; n++) begin
      c = cur_m[n]; t = tgt_m[n]; r = rate_m[n];
      if (((en_m >> n) & 1) == 0) begin
        exp_busy += 2;
        continue;
      end
      if (r == 0)     nw = t;
      else if (c < t) nw = (c + r > t) ? t : c + r;
      else if (c > t) nw = (c - r < t) ? t : c - r;
      else            nw = c;
      if (nw == c) begin
        exp_busy += 2;
      end else begin
        exp_busy += 4;
        cur_m[n] = nw;
        exp_wr.push_back({8'(2 * n), 8'(nw % 256)});
        exp_wr.push_back({8'(2 * n + 1), 8'(nw / 256)});
      end
    end
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
    cfg_wen = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_wen = 1'b0;
    model_cfg(a, d);
  endtask

  task automatic cfg_check(input string name, input logic [7:0] a, input logic [7:0] exp);
    cfg_addr = a;
    #1;
    check(name, {24'b0, cfg_rdata}, {24'b0, exp});
  endtask

  task automatic set_target(input int ch, input int v);
    cfg_write(8'(2 * ch), 8'(v % 256));
    cfg_write(8'(2 * ch + 1), 8'(v / 256));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_wen = 1'b0; frame_tick = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  // Pulses ntick frame ticks (gap cycles apart), waits for busy to drop and
  // compares the captured bus writes against nframes of the model.
  task automatic run_multi(input string tag, input int ntick, input int gap,
                           input int nframes, input logic exp_ovr, output int n);
    int sent;
    exp_wr.delete();
    exp_busy = 0;
    for (int f = 0; f < nframes; f++) model_frame();
    last_base = got_wr.size();
    tick_cyc = cyc;
    frame_tick = 1'b1; sent = 1;
    @(posedge clk); #1;
    frame_tick = 1'b0; n = 1;
    while ((busy || sent < ntick) && n < 400) begin
      if (sent < ntick && n % gap == 0) begin
        frame_tick = 1'b1; sent++;
      end
      @(posedge clk); #1;
      frame_tick = 1'b0; n++;
    end
    check({tag, " busy_len"}, n, exp_busy + 1);
    check({tag, " wr_count"}, got_wr.size() - last_base, exp_wr.size());
    for (int i = 0; i < exp_wr.size() && last_base + i < got_wr.size(); i++)
      check($sformatf("%s wr[%0d]", tag, i), {16'b0, got_wr[last_base + i]}, {16'b0, exp_wr[i]});
    check({tag, " overrun"}, {31'b0, overrun}, {31'b0, exp_ovr});
  endtask

  task automatic check_width(input string tag, input int ch, input int exp);
    check({tag, " count"}, got_wr.size() - last_base, 2);
    if (got_wr.size() - last_base == 2) begin
      check({tag, " addr_lo"}, {24'b0, got_wr[last_base][15:8]}, 2 * ch);
      check({tag, " addr_hi"}, {24'b0, got_wr[last_base + 1][15:8]}, 2 * ch + 1);
      check({tag, " width"}, {16'b0, got_wr[last_base + 1][7:0], got_wr[last_base][7:0]}, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ch, v;
    vecs[0]  = '{1'b1, 8'h00, 8'h34, 8'h34};
    vecs[1]  = '{1'b1, 8'h01, 8'h12, 8'h12};
    vecs[2]  = '{1'b1, 8'h20, 8'h64, 8'h64};
    vecs[3]  = '{1'b1, 8'h30, 8'h0F, 8'h0F};
    vecs[4]  = '{1'b1, 8'h04, 8'h30, 8'h30};
    vecs[5]  = '{1'b1, 8'h05, 8'h75, 8'h4E};
    vecs[6]  = '{1'b0, 8'h04, 8'h00, 8'h20};
    vecs[7]  = '{1'b1, 8'h10, 8'hAA, 8'h00};
    vecs[8]  = '{1'b0, 8'h31, 8'h00, 8'h00};
    vecs[9]  = '{1'b1, 8'h40, 8'h55, 8'h00};
    vecs[10] = '{1'b0, 8'h27, 8'h00, 8'h00};
    vecs[11] = '{1'b1, 8'h27, 8'hFF, 8'hFF};
    vecs[12] = '{1'b0, 8'hFF, 8'h00, 8'h00};

    model_reset();
    @(posedge clk); #1;
    check("reset pwm_wen", {31'b0, pwm_wen}, 0);
    check("reset pwm_addr", {24'b0, pwm_addr}, 0);
    check("reset pwm_wdata", {24'b0, pwm_wdata}, 0);
    check("reset busy", {31'b0, busy}, 0);
    check("reset overrun", {31'b0, overrun}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) cfg_write(vecs[i].addr, vecs[i].wdata);
      cfg_check($sformatf("regmap vec%0d", i), vecs[i].addr, vecs[i].exp_rd);
    end

    // basic upward ramp
    do_reset();
    set_target(0, 1500);
    cfg_write(8'h20, 8'd100);
    cfg_write(8'h30, 8'h01);
    for (int k = 1; k <= 16; k++) begin
      run_multi($sformatf("ramp%0d", k), 1, 1, 1, 1'b0, n);
      if (k <= 15) check_width($sformatf("ramp%0d", k), 0, 100 * k);
      else check("ramp16 no_write", got_wr.size() - last_base, 0);
      if (k == 1) check("ramp1 latency", wr_cyc[last_base] - tick_cyc, 2);
    end

    // downward ramp and immediate jumps on channel 1
    do_reset();
    set_target(1, 1500);
    cfg_write(8'h30, 8'h02);
    run_multi("jump_up", 1, 1, 1, 1'b0, n);
    check_width("jump_up", 1, 1500);
    set_target(1, 1000);
    cfg_write(8'h21, 8'd200);
    for (int k = 0; k < 3; k++) begin
      run_multi($sformatf("down%0d", k), 1, 1, 1, 1'b0, n);
      check_width($sformatf("down%0d", k), 1, 1300 - 200 * k + ((k == 2) ? 100 : 0));
    end
    set_target(1, 1500);
    cfg_write(8'h21, 8'd0);
    run_multi("rejump_up", 1, 1, 1, 1'b0, n);
    set_target(1, 1000);
    run_multi("jump_down", 1, 1, 1, 1'b0, n);
    check_width("jump_down", 1, 1000);

    // clamp to MAX_WIDTH
    do_reset();
    cfg_write(8'h04, 8'h30);
    cfg_write(8'h05, 8'h75);
    cfg_check("clamp tgt_lo", 8'h04, 8'h20);
    cfg_check("clamp tgt_hi", 8'h05, 8'h4E);
    cfg_write(8'h30, 8'h04);
    run_multi("clamp", 1, 1, 1, 1'b0, n);
    check_width("clamp", 2, 20000);
    cfg_check("clamp cur_lo", 8'h44, 8'h20);
    cfg_check("clamp cur_hi", 8'h45, 8'h4E);

    // skip pattern and ordering
    do_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      set_target(c, 1000 + 37 * c);
      cfg_write(8'(8'h20 + c), 8'd50);
    end
    cfg_write(8'h30, 8'hA5);
    run_multi("skip", 1, 1, 1, 1'b0, n);
    check("skip within worst case", {31'b0, n <= 4 * NUM_CH + 1}, 1);
    if (got_wr.size() - last_base == 8) begin
      check("skip addr0", {24'b0, got_wr[last_base + 0][15:8]}, 8'h00);
      check("skip addr3", {24'b0, got_wr[last_base + 3][15:8]}, 8'h05);
      check("skip addr4", {24'b0, got_wr[last_base + 4][15:8]}, 8'h0A);
      check("skip addr7", {24'b0, got_wr[last_base + 7][15:8]}, 8'h0F);
    end

    // worst-case sequence, back-to-back overlap, overrun
    cfg_write(8'h30, 8'hFF);
    for (int c = 0; c < NUM_CH; c++) set_target(c, 10000);
    run_multi("all_en", 1, 1, 1, 1'b0, n);
    check("all_en busy drops after 33", n, 33);
    run_multi("overlap", 2, 5, 2, 1'b0, n);
    check("overlap back_to_back", n, 65);
    run_multi("overrun", 3, 5, 2, 1'b1, n);
    cfg_check("overrun status", 8'h31, 8'h02);
    cfg_write(8'h31, 8'h00);
    check("overrun cleared", {31'b0, overrun}, 0);
    cfg_check("overrun status clear", 8'h31, 8'h00);

    // reset while the low byte is on the bus
    do_reset();
    set_target(3, 1234);
    cfg_write(8'h30, 8'h08);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    n = 0;
    while (!pwm_wen && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("rst_mid reached wr_lo", {31'b0, pwm_wen}, 1);
    check("rst_mid addr", {24'b0, pwm_addr}, 8'h06);
    rst_n = 1'b0;
    #1;
    check("rst_mid pwm_wen", {31'b0, pwm_wen}, 0);
    check("rst_mid busy", {31'b0, busy}, 0);
    check("rst_mid pwm_addr", {24'b0, pwm_addr}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    cfg_check("rst_mid tgt_lo", 8'h06, 8'h00);
    cfg_check("rst_mid tgt_hi", 8'h07, 8'h00);
    cfg_check("rst_mid en", 8'h30, 8'h00);
    cfg_check("rst_mid status", 8'h31, 8'h00);
    cfg_check("rst_mid cur_lo", 8'h46, 8'h00);
    cfg_check("rst_mid cur_hi", 8'h47, 8'h00);

    // randomized configuration and frames against the model
    for (int it = 0; it < 30; it++) begin
      for (int op = 0; op < int'($urandom_range(1, 4)); op++) begin
        ch = int'($urandom_range(0, NUM_CH - 1));
        case ($urandom_range(0, 2))
          0: set_target(ch, int'($urandom_range(0, 30000)));
          1: cfg_write(8'(8'h20 + ch), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
          default: cfg_write(8'h30, 8'($urandom_range(0, 255)));
        endcase
      end
      run_multi($sformatf("rand%0d", it), 1, 1, 1, 1'b0, n);
      ch = int'($urandom_range(0, NUM_CH - 1));
      v = cur_m[ch];
      cfg_check($sformatf("rand%0d cur_lo", it), 8'(8'h40 + 2 * ch), 8'(v % 256));
      cfg_check($sformatf("rand%0d cur_hi", it), 8'(8'h41 + 2 * ch), 8'(v / 256));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
